// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage of the single-issue core.
// Owns the PC and presents it to instruction memory. Captures the returned
// word into the IF/ID register. Handles hazard stalls, branch/jump redirects,
// halting on an all-zero word, and illegal-address faults.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr         byte address to instruction memory (the PC register)
//   imem_instr        instruction word for imem_addr (combinational return)
//   stall             hazard unit hold request
//   redirect_valid    taken branch/jump from EX
//   redirect_target   byte address of the redirect target
//   if_id_valid       IF/ID holds a real instruction
//   if_id_pc          PC of the instruction in IF/ID
//   if_id_instr       instruction in IF/ID
//   halted            high while halted on a zero word
//   fault             high after an illegal address; sticky until reset
//   fetch_count       instructions loaded into IF/ID (wraps)
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS   = 1280,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // 33 bits so the limit itself and the comparison cannot overflow
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        target_legal;
  logic        pc_in_range;

  assign target_legal = (redirect_target[1:0] == 2'b00) &&
                        ({1'b0, redirect_target} < PC_LIMIT);
  assign pc_in_range  = ({1'b0, pc} < PC_LIMIT);
  assign imem_addr    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;

        RUN: begin
          if (redirect_valid) begin
            // redirect wins over stall; the word in IF/ID is on the wrong path
            if_id_valid <= 1'b0;
            if (target_legal) begin
              pc <= redirect_target;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (stall) begin
            // hold everything
          end else if (!pc_in_range) begin
            // checked before the increment can wrap past the top of memory
            state       <= FAULT;
            fault       <= 1'b1;
            if_id_valid <= 1'b0;
          end else if (HALT_ON_ZERO && (imem_instr == '0)) begin
            state       <= HALT;
            halted      <= 1'b1;
            if_id_valid <= 1'b0;
          end else begin
            if_id_pc    <= pc;
            if_id_instr <= imem_instr;
            if_id_valid <= 1'b1;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
          end
        end

        HALT: begin
          if (redirect_valid) begin
            halted <= 1'b0;
            if (target_legal) begin
              pc    <= redirect_target;
              state <= RUN;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end

        FAULT: begin
          if_id_valid <= 1'b0;
        end

        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the single-issue core, directly upstream of the instruction memory and downstream-facing to the decoder. It owns the program counter and drives it combinationally as the word-aligned byte address into instruction memory. It captures the returned instruction into the IF/ID pipeline register. It handles hazard stalls, branch/jump redirects, end-of-program halt on an all-zero word, and illegal-address faults.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
- IMEM_WORDS, 1280, instruction memory depth in 32-bit words; legal PC range is 0 to IMEM_WORDS*4-4
- HALT_ON_ZERO, 1, when 1 an all-zero instruction word ends the program

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_addr  output  32  byte address to instruction memory; always equals the PC register
- imem_instr  input  32  instruction word returned combinationally for imem_addr
- stall  input  1  hazard unit request to hold PC and IF/ID
- redirect_valid  input  1  taken branch/jump from EX
- redirect_target  input  32  byte address of redirect target
- if_id_valid  output  1  IF/ID register holds a real instruction
- if_id_pc  output  32  PC of the instruction in IF/ID
- if_id_instr  output  32  instruction in IF/ID
- halted  output  1  high in HALT state
- fault  output  1  high in FAULT state; sticky until reset
- fetch_count  output  32  number of instructions loaded into IF/ID

## Operation
- States are BOOT, RUN, HALT and FAULT.
- **Reset (rst_n low, asynchronous):** state=BOOT, pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=0, halted=0, fault=0, fetch_count=0.
- **BOOT:** lasts one cycle with no capture into IF/ID, then goes to RUN. The redirect and stall inputs are ignored.
- **RUN** uses this per-cycle priority (highest first):
  1. redirect_valid with a legal target (target[1:0]==0 and target < IMEM_WORDS*4): pc<=target, if_id_valid<=0 (flush), fetch_count unchanged. A redirect overrides a simultaneous stall.
  2. redirect_valid with an illegal target: go to FAULT, pc held, if_id_valid<=0.
  3. stall: pc, IF/ID registers and fetch_count are all held.
  4. pc >= IMEM_WORDS*4: go to FAULT, if_id_valid<=0.
  5. HALT_ON_ZERO and imem_instr==0: go to HALT, if_id_valid<=0, pc held. The zero word is never loaded into IF/ID.
  6. Otherwise: if_id_pc<=pc, if_id_instr<=imem_instr, if_id_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
- **HALT:** halted=1 and pc is held.
  - A legal redirect sets pc<=target, halted<=0 and returns to RUN. This covers a branch already in EX jumping past the zero word.
  - An illegal redirect goes to FAULT.
  - stall has no effect.
- **FAULT:** fault=1 and if_id_valid=0. All inputs are ignored until reset.
- **Arithmetic:** PC increment is 32-bit modulo, and the range check catches overflow before wrap. fetch_count wraps from 2^32-1 to 0.

## Timing
- imem_addr is a direct register output with no combinational path from inputs.
- imem_instr is sampled in the same cycle imem_addr is presented.
- **Latency:**
  - PC to IF/ID is 1 cycle.
  - After a redirect, the first instruction from the target appears in IF/ID 2 edges later: one flush cycle, then the target word.
  - After reset release, the instruction at RESET_PC appears in IF/ID on the second rising edge (BOOT, then capture).
- halted and fault rise on the same edge as the state change.
- rst_n assertion clears all outputs immediately, without waiting for an edge. Deassertion is sampled on the next rising edge.

## Test plan
- **Straight-line program:** 12 nonzero words at addresses 0..44, then a zero word.
  - Required: if_id_pc goes 0,4,...,44 on consecutive cycles with if_id_valid=1.
  - Then halted=1 with imem_addr=48 and fetch_count=12.
- **Stall:** stall held high for 3 cycles while imem_addr=8.
  - Required: if_id_pc=4 is held, imem_addr stays 8, and fetch_count is unchanged.
  - On the cycle after stall falls, if_id_pc=8.
- **Redirect during stall:** redirect_valid=1, redirect_target=0x20 and stall=1 in the same cycle.
  - Required: next cycle if_id_valid=0 and imem_addr=0x20.
  - The following cycle if_id_pc=0x20 with if_id_valid=1.
- **Illegal targets:** a redirect to 0x22 (misaligned) sets fault=1 and if_id_valid=0.
  - A subsequent redirect to 0x0 is ignored.
  - Separately, a redirect to 0x1400 (IMEM_WORDS*4) also sets fault=1.
- **Resume from HALT:** in HALT, a redirect to 0x10 gives halted=0 and imem_addr=0x10, then if_id_pc=0x10 one cycle later.
- **Asynchronous reset mid-run:** rst_n driven low between clock edges while if_id_valid=1.
  - Required: if_id_valid, fetch_count, halted and fault go to 0 and imem_addr goes to RESET_PC before the next edge.
  - After release, the BOOT cycle is observed.
